// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC scan sequencer and its SPI frame engine.
package adc_scan_pkg;

  typedef enum logic [1:0] {IDLE, GAP, FRAME, LATCH} state_t;
  typedef enum logic [1:0] {CHAN_IL, CHAN_VIN, CHAN_VOUT} chan_t;

  localparam int FRAME_BITS  = 16;
  localparam int RESULT_BITS = 12;
  localparam int ADDR_MSB    = 13;
  localparam int ADDR_LSB    = 11;

  localparam logic [2:0] CH_IL_DEFAULT   = 3'd0;
  localparam logic [2:0] CH_VIN_DEFAULT  = 3'd1;
  localparam logic [2:0] CH_VOUT_DEFAULT = 3'd2;

  function automatic logic [FRAME_BITS-1:0] build_tx_word(input logic [2:0] addr);
    logic [FRAME_BITS-1:0] w;
    w = '0;
    w[ADDR_MSB:ADDR_LSB] = addr;
    return w;
  endfunction

  function automatic chan_t next_chan(input chan_t c);
    case (c)
      CHAN_IL:  return CHAN_VIN;
      CHAN_VIN: return CHAN_VOUT;
      default:  return CHAN_IL;
    endcase
  endfunction

endpackage

// File: rtl/adc_spi_frame.sv
// One 16-bit SPI frame: SCLK low/high halves of CLK_DIV cycles, din on falling edge,
// dout registered then sampled on rising edge; done is combinational on the final half-period end.
module adc_spi_frame
  import adc_scan_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [FRAME_BITS-1:0]  tx_word,
  output logic                   done,
  output logic [RESULT_BITS-1:0] rx_result,
  output logic                   sclk,
  output logic                   din,
  input  logic                   dout
);

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
  localparam logic [3:0] BIT_FIRST  = 4'(FRAME_BITS - 1);

  logic                   busy;
  logic                   high_phase;
  logic                   dout_q;
  logic [7:0]             div_cnt;
  logic [3:0]             bit_idx;
  logic [FRAME_BITS-1:0]  tx_q;
  logic [RESULT_BITS-1:0] rx_shift;

  assign done      = busy && (div_cnt == 8'd0) && high_phase && (bit_idx == 4'd0);
  assign rx_result = rx_shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      high_phase <= 1'b0;
      div_cnt    <= 8'd0;
      bit_idx    <= 4'd0;
      tx_q       <= '0;
      rx_shift   <= '0;
      sclk       <= 1'b1;
      din        <= 1'b0;
      dout_q     <= 1'b0;
    end else begin
      dout_q <= dout;
      if (start) begin
        busy       <= 1'b1;
        high_phase <= 1'b0;
        div_cnt    <= DIV_RELOAD;
        bit_idx    <= BIT_FIRST;
        tx_q       <= tx_word;
        sclk       <= 1'b0;
        din        <= tx_word[FRAME_BITS-1];
      end else if (busy) begin
        if (div_cnt != 8'd0) begin
          div_cnt <= div_cnt - 8'd1;
        end else if (!high_phase) begin
          high_phase <= 1'b1;
          div_cnt    <= DIV_RELOAD;
          sclk       <= 1'b1;
          rx_shift   <= {rx_shift[RESULT_BITS-2:0], dout_q};
        end else if (bit_idx == 4'd0) begin
          // Last high half done: SCLK simply stays at its idle-high level.
          busy <= 1'b0;
        end else begin
          high_phase <= 1'b0;
          div_cnt    <= DIV_RELOAD;
          bit_idx    <= bit_idx - 4'd1;
          sclk       <= 1'b0;
          din        <= tx_q[bit_idx - 4'd1];
        end
      end
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin IL/VIN/VOUT ADC scanner; results update 1 clk after adc_cs_n rises.
// Each frame returns data for the address sent in the previous frame, so the first frame after IDLE is dropped.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int         CLK_DIV    = 4,
  parameter int         GAP_CYCLES = 8,
  parameter logic [2:0] CH_IL      = CH_IL_DEFAULT,
  parameter logic [2:0] CH_VIN     = CH_VIN_DEFAULT,
  parameter logic [2:0] CH_VOUT    = CH_VOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [9:0]  il_adc,
  output logic [11:0] vin_adc,
  output logic [11:0] vout_adc,
  output logic [2:0]  sample_valid
);

  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t                 state;
  chan_t                  send_chan;
  chan_t                  data_chan;
  logic                   pipe_valid;
  logic [7:0]             gap_cnt;
  logic                   frame_start;
  logic                   frame_done;
  logic [2:0]             send_addr;
  logic [FRAME_BITS-1:0]  tx_word;
  logic [RESULT_BITS-1:0] rx_result;

  always_comb begin
    case (send_chan)
      CHAN_VIN:  send_addr = CH_VIN;
      CHAN_VOUT: send_addr = CH_VOUT;
      default:   send_addr = CH_IL;
    endcase
  end

  assign tx_word     = build_tx_word(send_addr);
  assign frame_start = (state == GAP) && (gap_cnt == GAP_LAST);

  adc_spi_frame #(
    .CLK_DIV (CLK_DIV)
  ) u_frame (
    .clk       (clk),
    .reset     (reset),
    .start     (frame_start),
    .tx_word   (tx_word),
    .done      (frame_done),
    .rx_result (rx_result),
    .sclk      (adc_sclk),
    .din       (adc_din),
    .dout      (adc_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      adc_cs_n     <= 1'b1;
      gap_cnt      <= 8'd0;
      pipe_valid   <= 1'b0;
      send_chan    <= CHAN_IL;
      data_chan    <= CHAN_IL;
      il_adc       <= '0;
      vin_adc      <= '0;
      vout_adc     <= '0;
      sample_valid <= '0;
    end else begin
      sample_valid <= '0;
      case (state)
        IDLE: begin
          pipe_valid <= 1'b0;
          send_chan  <= CHAN_IL;
          gap_cnt    <= 8'd0;
          if (enable) state <= GAP;
        end
        GAP: begin
          if (frame_start) begin
            state    <= FRAME;
            adc_cs_n <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        FRAME: begin
          if (frame_done) begin
            state    <= LATCH;
            adc_cs_n <= 1'b1;
          end
        end
        LATCH: begin
          if (pipe_valid) begin
            case (data_chan)
              CHAN_IL: begin
                il_adc       <= rx_result[RESULT_BITS-1:2];
                sample_valid <= 3'b001;
              end
              CHAN_VIN: begin
                vin_adc      <= rx_result;
                sample_valid <= 3'b010;
              end
              CHAN_VOUT: begin
                vout_adc     <= rx_result;
                sample_valid <= 3'b100;
              end
              default: ;
            endcase
          end
          pipe_valid <= 1'b1;
          data_chan  <= send_chan;
          send_chan  <= next_chan(send_chan);
          gap_cnt    <= 8'd0;
          state      <= enable ? GAP : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
